// File: rtl/arb_pkg.sv
// Shared types and helpers for the SEU-hardened round-robin arbiter:
// state encoding, {state, owner} packing, Hamming(7,4) encoder and round-robin pick.
package arb_pkg;

  localparam int DATA_W  = 4;
  localparam int CODE_W  = 7;
  localparam int MAX_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_SPARE   = 2'd3
  } state_e;

  typedef struct packed {
    state_e     state;
    logic [1:0] owner;
  } word_t;

  function automatic logic [DATA_W-1:0] pack_f(state_e st, logic [1:0] ow);
    return {st, ow};
  endfunction

  function automatic word_t unpack_f(logic [DATA_W-1:0] d);
    word_t w;
    w.state = state_e'(d[3:2]);
    w.owner = d[1:0];
    return w;
  endfunction

  // Codeword bit i holds Hamming position i+1; parity sits at positions 1, 2 and 4.
  function automatic logic [CODE_W-1:0] encode_f(logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[3] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

  function automatic logic [1:0] rr_pick(logic [MAX_REQ-1:0] req, logic [1:0] last, int num);
    logic [1:0] pick;
    logic       found;
    int         idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = (int'(last) + i) % num;
      if (i <= num && !found && req[idx[1:0]]) begin
        pick  = idx[1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/h3_correct_n_k.sv
// Single-error-correcting Hamming decoder: corrects one flipped bit of an
// N-bit codeword and returns the K data bits plus a correction flag.
module h3_correct_n_k #(
  parameter int N = 7,
  parameter int K = 4
) (
  input  logic [N-1:0] code_i,
  output logic [K-1:0] data_o,
  output logic         sec_o
);

  localparam int SYN_W = $clog2(N + 1);

  logic [SYN_W-1:0] syn_s;
  logic [N-1:0]     fixed_s;

  // Syndrome, single-bit fix and extraction of the non-parity positions.
  always_comb begin
    int j;
    syn_s   = '0;
    fixed_s = code_i;
    data_o  = '0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      if (code_i[i]) begin
        syn_s = syn_s ^ SYN_W'(i + 1);
      end else begin
        syn_s = syn_s;
      end
    end
    if (syn_s != '0 && int'(syn_s) <= N) begin
      fixed_s[int'(syn_s) - 1] = ~code_i[int'(syn_s) - 1];
    end else begin
      fixed_s = code_i;
    end
    for (int i = 0; i < N; i++) begin
      if (((i + 1) & i) != 0) begin
        if (j < K) begin
          data_o[j] = fixed_s[i];
        end else begin
          data_o = data_o;
        end
        j = j + 1;
      end else begin
        j = j;
      end
    end
    sec_o = (syn_s != '0);
  end

endmodule

// File: rtl/hamming_rr_arbiter.sv
// Round-robin arbiter for up to 4 requesters whose {state, owner} lives in a
// Hamming(7,4) codeword that is corrected before use and rewritten every cycle.
module hamming_rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 1023,
  parameter int SEC_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ-1:0]   done_i,
  input  logic [6:0]           inj_err_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic [1:0]           owner_o,
  output logic                 sec_o,
  output logic [SEC_CNT_W-1:0] sec_cnt_o,
  output logic                 timeout_o
);

  localparam int                CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [1:0]        LAST_OWNER = 2'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]  TMO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CODE_W-1:0] RESET_CODE = encode_f(pack_f(ST_IDLE, LAST_OWNER));

  logic [CODE_W-1:0]    code_r;
  logic [DATA_W-1:0]    data_s;
  logic                 sec_s;
  word_t                cur_s;
  logic                 legal_s;
  state_e               nxt_state_s;
  logic [1:0]           nxt_owner_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic                 tmo_fire_s;
  logic                 sec_r;
  logic                 tmo_r;
  logic [SEC_CNT_W-1:0] sec_cnt_r;
  logic [MAX_REQ-1:0]   req_pad_s;
  logic [NUM_REQ-1:0]   grant_s;

  h3_correct_n_k #(.N(CODE_W), .K(DATA_W)) u_corr (
    .code_i (code_r),
    .data_o (data_s),
    .sec_o  (sec_s)
  );

  assign cur_s     = unpack_f(data_s);
  assign legal_s   = (cur_s.state != ST_SPARE) && (int'(cur_s.owner) < NUM_REQ);
  assign req_pad_s = MAX_REQ'(req_i);

  // Next-state / next-owner decision from the corrected word only.
  always_comb begin
    nxt_state_s = ST_IDLE;
    nxt_owner_s = cur_s.owner;
    cnt_nxt_s   = '0;
    tmo_fire_s  = 1'b0;
    if (!legal_s) begin
      nxt_state_s = ST_IDLE;
      nxt_owner_s = LAST_OWNER;
    end else begin
      case (cur_s.state)
        ST_IDLE: begin
          if (|req_i) begin
            nxt_state_s = ST_BUSY;
            nxt_owner_s = rr_pick(req_pad_s, cur_s.owner, NUM_REQ);
          end else begin
            nxt_state_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (done_i[cur_s.owner] || !req_i[cur_s.owner] || cnt_r == TMO_LAST) begin
            nxt_state_s = ST_RELEASE;
            tmo_fire_s  = (cnt_r == TMO_LAST) && !done_i[cur_s.owner];
          end else begin
            nxt_state_s = ST_BUSY;
            cnt_nxt_s   = cnt_r + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          nxt_state_s = ST_IDLE;
        end
        default: begin
          nxt_state_s = ST_IDLE;
          nxt_owner_s = LAST_OWNER;
        end
      endcase
    end
  end

  // Codeword, hold counter and status registers; injection mask only affects writes.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      code_r    <= RESET_CODE;
      cnt_r     <= '0;
      sec_r     <= 1'b0;
      tmo_r     <= 1'b0;
      sec_cnt_r <= '0;
    end else begin
      code_r <= encode_f(pack_f(nxt_state_s, nxt_owner_s)) ^ inj_err_i;
      cnt_r  <= cnt_nxt_s;
      sec_r  <= sec_s;
      tmo_r  <= tmo_fire_s;
      if (sec_s && sec_cnt_r != {SEC_CNT_W{1'b1}}) begin
        sec_cnt_r <= sec_cnt_r + SEC_CNT_W'(1);
      end else begin
        sec_cnt_r <= sec_cnt_r;
      end
    end
  end

  // Moore grant decode; an illegal word never grants.
  always_comb begin
    grant_s = '0;
    if (legal_s && cur_s.state == ST_BUSY) begin
      grant_s[cur_s.owner] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign grant_o   = grant_s;
  assign busy_o    = legal_s && (cur_s.state == ST_BUSY);
  assign owner_o   = cur_s.owner;
  assign sec_o     = sec_r;
  assign sec_cnt_o = sec_cnt_r;
  assign timeout_o = tmo_r;

endmodule

// File: tb/tb_hamming_rr_arbiter.sv
// Directed self-checking bench: one instance with a long timeout for arbitration
// and SEU scrubbing, one with TIMEOUT=8 / SEC_CNT_W=2 for forced release and saturation.
module tb_hamming_rr_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a, rst_n_b;
  logic [3:0] req_a, done_a, req_b, done_b;
  logic [6:0] inj_a, inj_b;
  logic [3:0] grant_a, grant_b;
  logic       busy_a, busy_b, sec_a, sec_b, tmo_a, tmo_b;
  logic [1:0] owner_a, owner_b;
  logic [7:0] sec_cnt_a;
  logic [1:0] sec_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  hamming_rr_arbiter #(.NUM_REQ(4), .TIMEOUT(64), .SEC_CNT_W(8)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n_a), .req_i(req_a), .done_i(done_a), .inj_err_i(inj_a),
    .grant_o(grant_a), .busy_o(busy_a), .owner_o(owner_a), .sec_o(sec_a),
    .sec_cnt_o(sec_cnt_a), .timeout_o(tmo_a)
  );

  hamming_rr_arbiter #(.NUM_REQ(4), .TIMEOUT(8), .SEC_CNT_W(2)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n_b), .req_i(req_b), .done_i(done_b), .inj_err_i(inj_b),
    .grant_o(grant_b), .busy_o(busy_b), .owner_o(owner_b), .sec_o(sec_b),
    .sec_cnt_o(sec_cnt_b), .timeout_o(tmo_b)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n_a = 1'b0;
    req_a   = 4'b1111;
    tick();
    tick();
    n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b expected 0000", grant_a); end
    n_checks++; if (owner_a !== 2'd3) begin n_fail++; $display("FAIL reset_owner: got %0d expected 3", owner_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    n_checks++; if (sec_cnt_a !== 8'd0) begin n_fail++; $display("FAIL reset_sec_cnt: got %0d expected 0", sec_cnt_a); end
    n_checks++; if (sec_a !== 1'b0 || tmo_a !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got sec=%b tmo=%b expected 0 0", sec_a, tmo_a); end
    rst_n_a = 1'b1;
    tick();
    n_checks++; if (grant_a !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", grant_a); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      n_checks++; if (grant_a !== exp) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, grant_a, exp); end
      for (int c = 0; c < 3; c++) begin
        tick();
        n_checks++; if (grant_a !== exp) begin n_fail++; $display("FAIL rr_hold[%0d]: got %b expected %b", k, grant_a, exp); end
      end
      done_a = exp;
      if (k == 4) req_a = 4'b0000;
      tick();
      done_a = 4'b0000;
      n_checks++; if (grant_a !== 4'b0000 || tmo_a !== 1'b0) begin n_fail++; $display("FAIL rr_release[%0d]: got grant=%b tmo=%b expected 0000 0", k, grant_a, tmo_a); end
      tick();
      n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL rr_idle_gap[%0d]: got %b expected 0000", k, grant_a); end
      if (k < 4) tick();
    end
  endtask

  task automatic test_withdrawal;
    req_a = 4'b0100;
    tick();
    n_checks++; if (grant_a !== 4'b0100) begin n_fail++; $display("FAIL wd_grant: got %b expected 0100", grant_a); end
    tick();
    req_a = 4'b1000;
    tick();
    n_checks++; if (grant_a !== 4'b0000 || tmo_a !== 1'b0) begin n_fail++; $display("FAIL wd_release: got grant=%b tmo=%b expected 0000 0", grant_a, tmo_a); end
    tick();
    n_checks++; if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL wd_idle: got %b expected 0000", grant_a); end
    tick();
    n_checks++; if (grant_a !== 4'b1000) begin n_fail++; $display("FAIL wd_next: got %b expected 1000", grant_a); end
    req_a = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid;
    req_a = 4'b0100;
    tick();
    n_checks++; if (grant_a !== 4'b0100 || busy_a !== 1'b1) begin n_fail++; $display("FAIL mid_grant: got grant=%b busy=%b expected 0100 1", grant_a, busy_a); end
    rst_n_a = 1'b0;
    tick();
    n_checks++; if (grant_a !== 4'b0000 || busy_a !== 1'b0 || owner_a !== 2'd3) begin n_fail++; $display("FAIL mid_reset: got grant=%b busy=%b owner=%0d expected 0000 0 3", grant_a, busy_a, owner_a); end
    rst_n_a = 1'b1;
    req_a   = 4'b0000;
    tick();
  endtask

  task automatic test_seu;
    req_a = 4'b0010;
    tick();
    n_checks++; if (grant_a !== 4'b0010) begin n_fail++; $display("FAIL seu_grant: got %b expected 0010", grant_a); end
    for (int m = 0; m < 7; m++) begin
      inj_a = 7'b0000001 << m;
      tick();
      inj_a = 7'b0000000;
      n_checks++; if (grant_a !== 4'b0010 || owner_a !== 2'd1 || busy_a !== 1'b1) begin n_fail++; $display("FAIL seu_corrupt[%0d]: got grant=%b owner=%0d busy=%b expected 0010 1 1", m, grant_a, owner_a, busy_a); end
      n_checks++; if (sec_a !== 1'b0) begin n_fail++; $display("FAIL seu_sec_early[%0d]: got %b expected 0", m, sec_a); end
      tick();
      n_checks++; if (sec_a !== 1'b1 || grant_a !== 4'b0010) begin n_fail++; $display("FAIL seu_sec[%0d]: got sec=%b grant=%b expected 1 0010", m, sec_a, grant_a); end
      n_checks++; if (sec_cnt_a !== 8'(m + 1)) begin n_fail++; $display("FAIL seu_cnt[%0d]: got %0d expected %0d", m, sec_cnt_a, m + 1); end
    end
    tick();
    n_checks++; if (sec_a !== 1'b0 || sec_cnt_a !== 8'd7) begin n_fail++; $display("FAIL seu_clean: got sec=%b cnt=%0d expected 0 7", sec_a, sec_cnt_a); end
    req_a = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_timeout;
    rst_n_b = 1'b0;
    req_b   = 4'b0110;
    tick();
    tick();
    rst_n_b = 1'b1;
    tick();
    n_checks++; if (grant_b !== 4'b0010) begin n_fail++; $display("FAIL tmo_grant: got %b expected 0010", grant_b); end
    for (int c = 2; c <= 8; c++) begin
      tick();
      n_checks++; if (grant_b !== 4'b0010 || tmo_b !== 1'b0) begin n_fail++; $display("FAIL tmo_hold[%0d]: got grant=%b tmo=%b expected 0010 0", c, grant_b, tmo_b); end
    end
    tick();
    n_checks++; if (grant_b !== 4'b0000 || tmo_b !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse: got grant=%b tmo=%b expected 0000 1", grant_b, tmo_b); end
    tick();
    n_checks++; if (grant_b !== 4'b0000 || tmo_b !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: got grant=%b tmo=%b expected 0000 0", grant_b, tmo_b); end
    tick();
    n_checks++; if (grant_b !== 4'b0100) begin n_fail++; $display("FAIL tmo_next: got %b expected 0100", grant_b); end
    req_b = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_saturation;
    int exp;
    for (int i = 0; i < 5; i++) begin
      inj_b = 7'b0000001 << i;
      tick();
      inj_b = 7'b0000000;
      n_checks++; if (grant_b !== 4'b0000 || busy_b !== 1'b0) begin n_fail++; $display("FAIL sat_idle[%0d]: got grant=%b busy=%b expected 0000 0", i, grant_b, busy_b); end
      tick();
      exp = (i + 1 > 3) ? 3 : i + 1;
      n_checks++; if (sec_b !== 1'b1 || sec_cnt_b !== 2'(exp)) begin n_fail++; $display("FAIL sat_cnt[%0d]: got sec=%b cnt=%0d expected 1 %0d", i, sec_b, sec_cnt_b, exp); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_a = 1'b0; req_a = 4'b0000; done_a = 4'b0000; inj_a = 7'b0000000;
    rst_n_b = 1'b0; req_b = 4'b0000; done_b = 4'b0000; inj_b = 7'b0000000;
    test_reset();
    test_round_robin();
    test_withdrawal();
    test_reset_mid();
    test_seu();
    test_timeout();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
